// File: rtl/sdx_kernel_wizard_0_pkg.sv
// Shared definitions for the kernel sequencer.
//   state_t            : sequencer states
//   C_WORD_BYTES_DFLT  : default bytes per AES word
//   C_WORD_SHIFT_DFLT  : log2 of the default word size (word -> byte offset)
//   clamp_chunk()      : words in the next command, min(remaining, max)
package sdx_kernel_wizard_0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int C_WORD_BYTES_DFLT = 16;
    localparam int C_WORD_SHIFT_DFLT = $clog2(C_WORD_BYTES_DFLT);

    function automatic logic [31:0] clamp_chunk(input logic [31:0] words,
                                                input logic [31:0] max_words);
        return (words > max_words) ? max_words : words;
    endfunction

endpackage

// File: rtl/sdx_kernel_wizard_0_ap_ctrl_if.sv
// Paired read/write command channels between the sequencer and the AXI4
// master read/write engines.
//   rd_cmd_valid/ready/addr/len, rd_done : read command + chunk-complete pulse
//   wr_cmd_valid/ready/addr/len, wr_done : write command + chunk-complete pulse
// master modport = sequencer side, slave modport = engine side.
interface sdx_kernel_wizard_0_ap_ctrl_if #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_MAX_CHUNK_WORDS = 256
);
    localparam int C_LEN_WIDTH = $clog2(C_MAX_CHUNK_WORDS) + 1;

    logic                    rd_cmd_valid;
    logic                    rd_cmd_ready;
    logic [C_ADDR_WIDTH-1:0] rd_cmd_addr;
    logic [C_LEN_WIDTH-1:0]  rd_cmd_len;
    logic                    rd_done;

    logic                    wr_cmd_valid;
    logic                    wr_cmd_ready;
    logic [C_ADDR_WIDTH-1:0] wr_cmd_addr;
    logic [C_LEN_WIDTH-1:0]  wr_cmd_len;
    logic                    wr_done;

    modport master (
        output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        input  rd_cmd_ready, rd_done,
        output wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        input  wr_cmd_ready, wr_done
    );

    modport slave (
        input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
        output rd_cmd_ready, rd_done,
        input  wr_cmd_valid, wr_cmd_addr, wr_cmd_len,
        output wr_cmd_ready, wr_done
    );

endinterface

// File: rtl/sdx_kernel_wizard_0_cmd_chan.sv
// Single valid/ready command holder with a sticky done flag.
//   aclk, areset_n       : clock, async active-low reset
//   load, load_addr/len  : present a new command (valid rises next cycle)
//   cmd_valid/ready      : AXI-style handshake, addr/len held while valid
//   cmd_addr, cmd_len    : held command fields
//   done, seen_en        : engine completion pulse, honoured only when enabled
//   clear_seen, seen     : sticky completion flag and its clear
module sdx_kernel_wizard_0_cmd_chan #(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_LEN_WIDTH  = 9
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    load,
    input  logic [C_ADDR_WIDTH-1:0] load_addr,
    input  logic [C_LEN_WIDTH-1:0]  load_len,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [C_ADDR_WIDTH-1:0] cmd_addr,
    output logic [C_LEN_WIDTH-1:0]  cmd_len,
    input  logic                    done,
    input  logic                    seen_en,
    input  logic                    clear_seen,
    output logic                    seen
);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            cmd_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            seen      <= 1'b0;
        end else begin
            if (load) begin
                cmd_valid <= 1'b1;
                cmd_addr  <= load_addr;
                cmd_len   <= load_len;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            // Clear wins: a completing chunk has already consumed the pulse.
            if (clear_seen) begin
                seen <= 1'b0;
            end else if (seen_en && done) begin
                seen <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdx_kernel_wizard_0_ap_ctrl.sv
// Kernel sequencer: splits a job of scalar00 words at axi00_ptr0 into chunks
// of at most C_MAX_CHUNK_WORDS and issues paired read/write commands.
//   aclk, areset_n       : clock, async active-low reset
//   ap_start             : level start, held until ap_done
//   ap_idle, ap_done     : idle level, one-cycle completion pulse
//   scalar00, axi00_ptr0 : word count and base byte address, sampled at start
//   cmd                  : read/write command channels (master modport)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no job; waiting for ap_start
// ST_ISSUE | rd/wr commands of current chunk offered until both accepted
// ST_WAIT  | both accepted; waiting for rd and wr chunk completion
// ST_DONE  | one-cycle ap_done, then back to idle
module sdx_kernel_wizard_0_ap_ctrl
    import sdx_kernel_wizard_0_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_MAX_CHUNK_WORDS = 256,
    parameter int C_WORD_BYTES      = C_WORD_BYTES_DFLT
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_done,
    input  logic [31:0]             scalar00,
    input  logic [C_ADDR_WIDTH-1:0] axi00_ptr0,
    sdx_kernel_wizard_0_ap_ctrl_if.master cmd
);

    localparam int          C_LEN_WIDTH  = $clog2(C_MAX_CHUNK_WORDS) + 1;
    localparam int          C_WORD_SHIFT = (C_WORD_BYTES == C_WORD_BYTES_DFLT) ?
                                           C_WORD_SHIFT_DFLT : $clog2(C_WORD_BYTES);
    localparam logic [31:0] C_MAX_W32    = 32'(C_MAX_CHUNK_WORDS);

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [31:0]             offset_q, offset_d;

    logic                    load, clear_seen, seen_en;
    logic                    rd_seen, wr_seen;
    logic [31:0]             chunk, next_chunk;
    logic [C_ADDR_WIDTH-1:0] load_addr;
    logic [C_LEN_WIDTH-1:0]  load_len;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            remaining_q <= '0;
            offset_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        clear_seen  = 1'b0;
        chunk       = clamp_chunk(remaining_q, C_MAX_W32);

        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    base_d      = axi00_ptr0;
                    remaining_d = scalar00;
                    offset_d    = '0;
                    state_d     = (scalar00 == 32'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A channel is accepted once its valid is gone or handshakes now.
                if ((!cmd.rd_cmd_valid || cmd.rd_cmd_ready) &&
                    (!cmd.wr_cmd_valid || cmd.wr_cmd_ready)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if ((rd_seen || cmd.rd_done) && (wr_seen || cmd.wr_done)) begin
                    clear_seen  = 1'b1;
                    remaining_d = remaining_q - chunk;
                    offset_d    = offset_q + chunk;
                    state_d     = (remaining_d == 32'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Next command is built from the post-update counters so back-to-back
        // chunks need no bubble cycle.
        load       = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
        next_chunk = clamp_chunk(remaining_d, C_MAX_W32);
        load_len   = C_LEN_WIDTH'(next_chunk);
        load_addr  = base_d + (C_ADDR_WIDTH'(offset_d) << C_WORD_SHIFT);
    end

    assign seen_en = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign ap_idle = (state_q == ST_IDLE);
    assign ap_done = (state_q == ST_DONE);

    sdx_kernel_wizard_0_cmd_chan #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_LEN_WIDTH  (C_LEN_WIDTH)
    ) u_rd_chan (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .load       (load),
        .load_addr  (load_addr),
        .load_len   (load_len),
        .cmd_valid  (cmd.rd_cmd_valid),
        .cmd_ready  (cmd.rd_cmd_ready),
        .cmd_addr   (cmd.rd_cmd_addr),
        .cmd_len    (cmd.rd_cmd_len),
        .done       (cmd.rd_done),
        .seen_en    (seen_en),
        .clear_seen (clear_seen),
        .seen       (rd_seen)
    );

    sdx_kernel_wizard_0_cmd_chan #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_LEN_WIDTH  (C_LEN_WIDTH)
    ) u_wr_chan (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .load       (load),
        .load_addr  (load_addr),
        .load_len   (load_len),
        .cmd_valid  (cmd.wr_cmd_valid),
        .cmd_ready  (cmd.wr_cmd_ready),
        .cmd_addr   (cmd.wr_cmd_addr),
        .cmd_len    (cmd.wr_cmd_len),
        .done       (cmd.wr_done),
        .seen_en    (seen_en),
        .clear_seen (clear_seen),
        .seen       (wr_seen)
    );

endmodule

// File: tb/tb_sdx_kernel_wizard_0_ap_ctrl.sv
// Bench for the kernel sequencer: table of directed jobs plus random jobs,
// engines modelled per channel, commands checked against a chunk list.
module tb_sdx_kernel_wizard_0_ap_ctrl;
    import sdx_kernel_wizard_0_pkg::*;

    localparam int MAXW = 256;
    localparam int WB   = C_WORD_BYTES_DFLT;
    localparam int TMO  = 4000;

    typedef struct {
        logic [31:0] scalar;
        logic [63:0] ptr;
        int          rrd, wrd, rdd, wdd;   // ready / done delays, -1 = random
        int          abort;                // cycles after first accept to reset, 0 = none
        int          exp_n;                // expected chunks, -1 = model only
        logic [63:0] exp_last;             // expected last chunk address
        int          lat;                  // expected start->ap_done cycles, -1 = skip
    } job_t;

    logic        aclk;
    logic        areset_n;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [31:0] scalar00;
    logic [63:0] axi00_ptr0;

    int n_cmp = 0;
    int n_err = 0;

    sdx_kernel_wizard_0_ap_ctrl_if #(.C_ADDR_WIDTH(64), .C_MAX_CHUNK_WORDS(MAXW)) cmd_if ();

    sdx_kernel_wizard_0_ap_ctrl #(
        .C_ADDR_WIDTH      (64),
        .C_MAX_CHUNK_WORDS (MAXW),
        .C_WORD_BYTES      (WB)
    ) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .ap_start   (ap_start),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .scalar00   (scalar00),
        .axi00_ptr0 (axi00_ptr0),
        .cmd        (cmd_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int d, input int lo, input int hi);
        return (d < 0) ? int'($urandom_range(hi, lo)) : d;
    endfunction

    task automatic drive_eng(input logic r0, input logic d0, input logic r1, input logic d1);
        cmd_if.rd_cmd_ready = r0;
        cmd_if.rd_done      = d0;
        cmd_if.wr_cmd_ready = r1;
        cmd_if.wr_done      = d1;
    endtask

    task automatic run_job(input job_t j);
        logic [63:0] exp_a[$];
        int          exp_l[$];
        longint unsigned rem, off, c;
        string       nm[2] = '{"rd", "wr"};
        int          idx[2], rcnt[2], dcnt[2], outst[2], l[2], pl[2];
        logic        v[2], pv[2], hs[2], hs_prev[2], rdy[2], dn[2];
        logic [63:0] a[2], pa[2], last_a;
        int          cyc, n_done, done_cyc, ab;
        bit          fin, aborted;

        // Reference: the job is a list of chunks of min(rem, MAXW) words at
        // consecutive word offsets from the base, addresses modulo 2^64.
        rem = longint'(j.scalar);
        off = 0;
        while (rem > 0) begin
            c = (rem > MAXW) ? MAXW : rem;
            exp_a.push_back(j.ptr + 64'(off * WB));
            exp_l.push_back(int'(c));
            rem -= c;
            off += c;
        end

        for (int k = 0; k < 2; k++) begin
            idx[k] = 0; dcnt[k] = 0; outst[k] = 0; pv[k] = 0; hs_prev[k] = 0;
            pa[k] = '0; pl[k] = 0;
        end
        rcnt[0] = pick(j.rrd, 0, 4);
        rcnt[1] = pick(j.wrd, 0, 4);
        last_a = '0; n_done = 0; done_cyc = -1; ab = 0; fin = 0; aborted = 0;

        @(negedge aclk);
        scalar00   = j.scalar;
        axi00_ptr0 = j.ptr;
        ap_start   = 1'b1;
        cyc = 0;

        while (!fin && cyc < TMO) begin
            @(negedge aclk);
            cyc++;
            if (cyc == 1) begin
                chk("idle_low_in_job", ap_idle, 1'b0);
                scalar00   = $urandom;
                axi00_ptr0 = {$urandom, $urandom};
            end
            if (j.abort > 0 && idx[0] > 0) begin
                ab++;
                if (ab == j.abort) begin
                    #2 areset_n = 1'b0;
                    #1;
                    chk("abort_idle", ap_idle, 1'b1);
                    chk("abort_done", ap_done, 1'b0);
                    chk("abort_rd_valid", cmd_if.rd_cmd_valid, 1'b0);
                    chk("abort_wr_valid", cmd_if.wr_cmd_valid, 1'b0);
                    ap_start = 1'b0;
                    drive_eng(0, 0, 0, 0);
                    @(negedge aclk);
                    areset_n = 1'b1;
                    repeat (2) @(negedge aclk);
                    chk("abort_no_ap_done", n_done, 0);
                    chk("abort_idle_after", ap_idle, 1'b1);
                    aborted = 1;
                    break;
                end
            end

            v[0] = cmd_if.rd_cmd_valid; a[0] = cmd_if.rd_cmd_addr; l[0] = int'(cmd_if.rd_cmd_len);
            v[1] = cmd_if.wr_cmd_valid; a[1] = cmd_if.wr_cmd_addr; l[1] = int'(cmd_if.wr_cmd_len);

            if (v[0] && !pv[0]) begin
                chk("valids_rise_together", v[1] && !pv[1], 1'b1);
                chk("prev_chunk_both_done", outst[0] + outst[1], 0);
            end

            for (int k = 0; k < 2; k++) begin
                if (pv[k] && !hs_prev[k]) begin
                    chk($sformatf("%s_valid_held", nm[k]), v[k], 1'b1);
                    chk($sformatf("%s_addr_stable", nm[k]), a[k], pa[k]);
                    chk($sformatf("%s_len_stable", nm[k]), l[k], pl[k]);
                end
                if (hs_prev[k])
                    chk($sformatf("%s_valid_drop", nm[k]), v[k], 1'b0);

                dn[k] = 0;
                if (dcnt[k] > 0) begin
                    dcnt[k]--;
                    if (dcnt[k] == 0) begin
                        dn[k] = 1;
                        outst[k]--;
                    end
                end

                rdy[k] = 0;
                hs[k]  = 0;
                if (v[k]) begin
                    if (rcnt[k] > 0) begin
                        rcnt[k]--;
                    end else begin
                        rdy[k] = 1;
                        hs[k]  = 1;
                        if (idx[k] >= exp_a.size()) begin
                            chk($sformatf("%s_extra_cmd", nm[k]), idx[k], exp_a.size());
                        end else begin
                            chk($sformatf("%s_cmd%0d_addr", nm[k], idx[k]), a[k], exp_a[idx[k]]);
                            chk($sformatf("%s_cmd%0d_len", nm[k], idx[k]), l[k], exp_l[idx[k]]);
                        end
                        if (k == 0) last_a = a[k];
                        idx[k]++;
                        outst[k]++;
                        dcnt[k] = pick((k == 0) ? j.rdd : j.wdd, 1, 6);
                        rcnt[k] = pick((k == 0) ? j.rrd : j.wrd, 0, 4);
                    end
                end
            end

            if (ap_done) begin
                n_done++;
                done_cyc = cyc;
                ap_start = 1'b0;
                dn[0] = 1;   // spurious completions while in DONE
                dn[1] = 1;
                fin = 1;
            end

            drive_eng(rdy[0], dn[0], rdy[1], dn[1]);
            pv = v; pa = a; pl = l; hs_prev = hs;
        end

        if (aborted) return;

        chk("ap_done_seen", fin, 1'b1);
        chk("rd_cmd_count", idx[0], exp_a.size());
        chk("wr_cmd_count", idx[1], exp_a.size());
        if (j.exp_n >= 0) chk("table_chunks", idx[0], j.exp_n);
        if (j.exp_n > 0) chk("table_last_addr", last_a, j.exp_last);
        if (j.lat >= 0) chk("done_latency", done_cyc, j.lat);

        @(negedge aclk);
        drive_eng(0, 0, 0, 0);
        chk("done_one_cycle", ap_done, 1'b0);
        chk("idle_after_done", ap_idle, 1'b1);
        chk("no_valid_after_done", cmd_if.rd_cmd_valid | cmd_if.wr_cmd_valid, 1'b0);
        repeat (2) @(negedge aclk);
    endtask

    job_t jobs[8];
    job_t rj;

    initial begin
        //          scalar  ptr                        rrd wrd rdd wdd abort exp_n exp_last                  lat
        jobs[0] = '{32'd0,   64'h1000,                 0,  0,  3,  3,  0,    0,    64'h0,                    1};
        jobs[1] = '{32'd5,   64'h2000,                 0,  0,  3,  3,  0,    1,    64'h2000,                 5};
        jobs[2] = '{32'd600, 64'h1_0000_0000,          0,  0,  3,  3,  0,    3,    64'h1_0000_2000,         -1};
        jobs[3] = '{32'd7,   64'h3000,                 4,  0,  6,  1,  0,    1,    64'h3000,                -1};
        jobs[4] = '{32'd257, 64'hFFFF_FFFF_FFFF_F000,  0,  0,  2,  2,  0,    2,    64'h0,                   -1};
        jobs[5] = '{32'd600, 64'h4000,                -1, -1, -1, -1,  0,    3,    64'h6000,                -1};
        jobs[6] = '{32'd600, 64'h5000,                 0,  0, 10, 10,  3,   -1,    64'h0,                   -1};
        jobs[7] = '{32'd600, 64'h5000,                 0,  0,  2,  5,  0,    3,    64'h7000,                -1};

        areset_n   = 1'b0;
        ap_start   = 1'b0;
        scalar00   = '0;
        axi00_ptr0 = '0;
        drive_eng(0, 0, 0, 0);
        #12;
        chk("reset_idle", ap_idle, 1'b1);
        chk("reset_done", ap_done, 1'b0);
        chk("reset_rd_valid", cmd_if.rd_cmd_valid, 1'b0);
        chk("reset_wr_valid", cmd_if.wr_cmd_valid, 1'b0);
        @(negedge aclk);
        areset_n = 1'b1;

        // Spurious completions in IDLE must not wake the sequencer.
        @(negedge aclk);
        drive_eng(0, 1, 0, 1);
        @(negedge aclk);
        drive_eng(0, 0, 0, 0);
        chk("spurious_idle", ap_idle, 1'b1);
        chk("spurious_no_valid", cmd_if.rd_cmd_valid | cmd_if.wr_cmd_valid, 1'b0);

        for (int i = 0; i < 8; i++) run_job(jobs[i]);

        for (int i = 0; i < 6; i++) begin
            rj = '{32'($urandom_range(1100, 1)), {$urandom, $urandom},
                   -1, -1, -1, -1, 0, -1, 64'h0, -1};
            run_job(rj);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdx_kernel_wizard_0_ap_ctrl.md
Name: sdx_kernel_wizard_0_ap_ctrl

Overview:
- Kernel-level sequencer directly downstream of the AXI4-Lite control register slave.
- Consumes ap_start, scalar00 (number of 128-bit AES words) and axi00_ptr0 (buffer base, encrypted in place).
- Splits the job into bounded chunks and issues paired read/write commands to the AXI4 master read and write engines.
- Returns ap_idle and a one-cycle ap_done to the control slave.

Parameters:
- C_ADDR_WIDTH, 64, byte-address width of the command address ports.
- C_MAX_CHUNK_WORDS, 256, maximum words per command; power of two, ≥1.
- C_WORD_BYTES, 16, bytes per word; power of two.
- C_LEN_WIDTH, $clog2(C_MAX_CHUNK_WORDS)+1, derived localparam; not overridable.

Ports:
- aclk  in  1  kernel clock
- areset_n  in  1  asynchronous active-low reset
- ap_start  in  1  level start from control slave; held until ap_done
- ap_idle  out  1  high when no job is active
- ap_done  out  1  one-cycle completion pulse
- scalar00  in  32  word count of the job
- axi00_ptr0  in  C_ADDR_WIDTH  buffer base byte address
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read engine accepts command
- rd_cmd_addr  out  C_ADDR_WIDTH  read chunk byte address
- rd_cmd_len  out  C_LEN_WIDTH  read chunk length in words, 1..C_MAX_CHUNK_WORDS
- rd_done  in  1  one-cycle pulse: read chunk fully delivered
- wr_cmd_valid/ready/addr/len  out/in/out/out  same widths  write command, same rules as read
- wr_done  in  1  one-cycle pulse: write chunk fully responded (all BRESP received)

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; ap_idle=1; ap_done=0; rd_cmd_valid=wr_cmd_valid=0; all internal counters 0.
- State IDLE:
  - ap_idle=1.
  - On ap_start=1: latch base←axi00_ptr0, remaining←scalar00, offset←0; ap_idle←0.
  - If scalar00==0, go to DONE; otherwise go to ISSUE.
  - ap_start=0: stay in IDLE.
- Entering ISSUE:
  - chunk = min(remaining, C_MAX_CHUNK_WORDS).
  - Both valids rise together.
  - addr = base + offset×C_WORD_BYTES, computed modulo 2^C_ADDR_WIDTH (wrap permitted, no error).
  - len = chunk. Read and write commands carry identical addr and len.
- ISSUE handshakes:
  - Each valid is AXI-style: held with stable addr/len until its own ready; then drops the next cycle.
  - Read and write handshakes are independent and may complete in either order or in the same cycle.
  - When both are accepted, go to WAIT.
- Done flags:
  - Sticky flags rd_seen and wr_seen are set by rd_done and wr_done in both ISSUE and WAIT, because a done may arrive before the other command is accepted.
  - Flags clear when a chunk completes.
- WAIT:
  - When rd_seen and wr_seen are both set (including rd_done and wr_done in the same cycle): remaining -= chunk, offset += chunk.
  - If remaining now 0, go to DONE; else go to ISSUE with the next chunk. No idle cycle between chunks is required.
- DONE:
  - ap_done=1 for exactly one cycle; ap_idle stays 0; next state IDLE with ap_idle=1.
  - The control slave clears its ap_start register on the ap_done edge, so IDLE sees ap_start=0 the following cycle.
  - A host start written later re-arms a new job.
- Spurious done pulses: rd_done or wr_done in IDLE or DONE are ignored.
- Argument stability: scalar00 and axi00_ptr0 changing mid-job has no effect; they are sampled only on IDLE→start.
- Reset mid-operation: immediate return to IDLE, valids low, flags cleared; no ap_done is generated.
- Width rules:
  - remaining is 32-bit unsigned; offset is 32-bit words.
  - Byte offset = offset×C_WORD_BYTES, extended to C_ADDR_WIDTH before the add.
  - scalar00 = 2^32-1 is legal; the final chunk is partial.

Decomposition:
- Shared package sdx_kernel_wizard_0_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}.
  - C_WORD_BYTES default and the derived log2 shift constant.
- One natural sub-module: sdx_kernel_wizard_0_cmd_chan.
  - A single valid/ready command holder with a sticky done flag.
  - Instantiated twice, once for read and once for write.

Test Plan:
- scalar00=0, ptr=0x1000, ap_start pulse held → ap_done one cycle after start; no rd_cmd_valid or wr_cmd_valid; ap_idle back to 1 next cycle.
- scalar00=5, ptr=0x2000, ready tied high, dones 3 cycles after accept → one command each, addr 0x2000, len 5; single ap_done.
- scalar00=600, ptr=0x1_0000_0000, C_MAX_CHUNK_WORDS=256 → three chunks, each addr on both rd and wr:
  - 0x1_0000_0000, len 256
  - 0x1_0000_1000, len 256
  - 0x1_0000_2000, len 88
  - then ap_done.
- rd_cmd_ready delayed 4 cycles, wr_done arrives before rd accept, rd_done later → addr/len stable while valid; chunk completes only after both dones; no duplicate command.
- rd_done and wr_done in the same cycle; ptr=0xFFFF_FFFF_FFFF_FFF0, scalar00=2, max=1 → second address wraps to 0x0; two chunks; one ap_done.
- areset_n asserted mid-WAIT of a 3-chunk job → outputs return to reset values asynchronously; no ap_done; a new start after release runs a clean job from chunk 0.
